// File: rtl/reg_bus_scan_reader_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : reg_bus_scan_reader_if                                           |
// | Purpose  : Control, shared-bus and readback signals of the scan reader.     |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
interface reg_bus_scan_reader_if #(
   parameter int NrOfBits = 32,
   parameter int NrOfRegs = 4
);
   localparam int IdxW = (NrOfRegs > 1) ? $clog2(NrOfRegs) : 1;

   logic                Tick;
   logic                start;
   logic                abort;
   logic [NrOfBits-1:0] bus_data;
   logic [NrOfRegs-1:0] cs;
   logic [NrOfBits-1:0] rd_data;
   logic [IdxW-1:0]     rd_index;
   logic                rd_valid;
   logic                done;
   logic                busy;

   modport master (
      input  Tick, start, abort, bus_data,
      output cs, rd_data, rd_index, rd_valid, done, busy
   );

   modport slave (
      output Tick, start, abort, bus_data,
      input  cs, rd_data, rd_index, rd_valid, done, busy
   );
endinterface
`default_nettype wire

// File: rtl/reg_bus_scan_reader.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : reg_bus_scan_reader                                              |
// | Purpose  : Walks the active-low selects of a shared register bus, captures  |
// |            each register after a settle time. SCAN_TURNAROUND_EN inserts a  |
// |            one-Tick all-released gap between selects.                       |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module reg_bus_scan_reader #(
   parameter int NrOfBits     = 32,
   parameter int NrOfRegs     = 4,
   parameter int SettleCycles = 1
) (
   input wire                    Clock,
   input wire                    Reset,
   reg_bus_scan_reader_if.master bus
);
   localparam int IdxW = (NrOfRegs > 1) ? $clog2(NrOfRegs) : 1;
   localparam int CntW = (SettleCycles > 0) ? $clog2(SettleCycles + 1) : 1;
   localparam logic [CntW-1:0] CntInit = CntW'(SettleCycles);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(NrOfRegs - 1);

`ifdef SCAN_TURNAROUND_EN
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SELECT = 2'd1, ST_TURN = 2'd2} state_t;
`else
   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SELECT = 1'b1} state_t;
`endif

   state_t              state_q,    state_d;
   logic [CntW-1:0]     cnt_q,      cnt_d;
   logic [IdxW-1:0]     idx_q,      idx_d;
   logic [NrOfRegs-1:0] cs_q,       cs_d;
   logic [NrOfBits-1:0] rd_data_q,  rd_data_d;
   logic [IdxW-1:0]     rd_index_q, rd_index_d;
   logic                rd_valid_q, rd_valid_d;
   logic                done_q,     done_d;
   logic                busy_q,     busy_d;

   // Active-low one-cold select for register i.
   function automatic logic [NrOfRegs-1:0] sel_mask(input logic [IdxW-1:0] i);
      logic [NrOfRegs-1:0] m;
      for (int k = 0; k < NrOfRegs; k++) begin
         m[k] = (IdxW'(k) != i);
      end
      return m;
   endfunction

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      cs_d       = cs_q;
      rd_data_d  = rd_data_q;
      rd_index_d = rd_index_q;
      rd_valid_d = 1'b0;
      done_d     = 1'b0;
      busy_d     = busy_q;

      // Abort ignores Tick and beats a capture falling on the same edge.
      if (bus.abort) begin
         state_d = ST_IDLE;
         cs_d    = '1;
         busy_d  = 1'b0;
      end else if (bus.Tick) begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  state_d = ST_SELECT;
                  idx_d   = '0;
                  cs_d    = sel_mask('0);
                  cnt_d   = CntInit;
                  busy_d  = 1'b1;
               end
            end
            ST_SELECT: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CntW'(1);
               end else begin
                  rd_data_d  = bus.bus_data;
                  rd_index_d = idx_q;
                  rd_valid_d = 1'b1;
                  if (idx_q == IdxLast) begin
                     done_d  = 1'b1;
                     cs_d    = '1;
                     busy_d  = 1'b0;
                     state_d = ST_IDLE;
                  end else begin
                     idx_d = idx_q + IdxW'(1);
                     cnt_d = CntInit;
`ifdef SCAN_TURNAROUND_EN
                     cs_d    = '1;
                     state_d = ST_TURN;
`else
                     cs_d    = sel_mask(idx_q + IdxW'(1));
`endif
                  end
               end
            end
`ifdef SCAN_TURNAROUND_EN
            ST_TURN: begin
               // idx already advanced on the capture edge.
               cs_d    = sel_mask(idx_q);
               state_d = ST_SELECT;
            end
`endif
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         cs_q       <= '1;
         rd_data_q  <= '0;
         rd_index_q <= '0;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         cs_q       <= cs_d;
         rd_data_q  <= rd_data_d;
         rd_index_q <= rd_index_d;
         rd_valid_q <= rd_valid_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.cs       = cs_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_index = rd_index_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.done     = done_q;
   assign bus.busy     = busy_q;
endmodule
`default_nettype wire
